// File: rtl/led_cmd_sched_if.sv
// Command/status and LED8 handshake bundle for led_cmd_sched.
// The master side is the CPU/LED environment; the slave side is the scheduler.
interface led_cmd_sched_if;
    logic        cmd_valid;
    logic [31:0] cmd_data;
    logic        cmd_ready;
    logic        status_clr;
    logic [31:0] led_state;
    logic        led_begin;
    logic [31:0] led_data;
    logic [31:0] sched_status;

    modport master (
        output cmd_valid, cmd_data, status_clr, led_state,
        input  cmd_ready, led_begin, led_data, sched_status
    );

    modport slave (
        input  cmd_valid, cmd_data, status_clr, led_state,
        output cmd_ready, led_begin, led_data, sched_status
    );
endinterface

// File: rtl/led_cmd_sched.sv
// led_cmd_sched: queues CPU commands for LED8 and runs the begin/busy handshake.
// Optional LED_SCHED_TIMEOUT_EN adds a per-phase handshake timeout (status bit 9).
//
// state     | meaning
// IDLE      | waiting for a queued command and LED not busy
// ISSUE     | one-cycle led_begin with FIFO head on led_data; head popped
// WAIT_ACK  | waiting for LED busy to rise
// WAIT_DONE | waiting for LED busy to fall
module led_cmd_sched #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic           clock,
    input  logic           reset_n,
    led_cmd_sched_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;
    state_t state, state_nxt;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, empty, push, pop, drop;
    logic          led_busy, begin_nxt, timeout_hit, to_set;
    logic          ovf_sticky, to_sticky;
    logic          led_begin_q;
    logic [31:0]   led_data_q;
    logic          unused_led_bits;

    assign led_busy        = bus.led_state[0];
    assign unused_led_bits = ^bus.led_state[31:1];
    assign full            = (count == CW'(DEPTH));
    assign empty           = (count == '0);
    // Fullness comes from the registered count, so a pop this cycle never frees a slot early.
    assign push            = bus.cmd_valid && !full;
    assign drop            = bus.cmd_valid && full;

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= bus.cmd_data;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef LED_SCHED_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TW-1:0] tmr;
    logic          wait_entry;

    assign wait_entry  = (state_nxt != state) && ((state_nxt == WAIT_ACK) || (state_nxt == WAIT_DONE));
    assign timeout_hit = ((state == WAIT_ACK) || (state == WAIT_DONE)) && (tmr == '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)          tmr <= '0;
        else if (wait_entry)   tmr <= TW'(TIMEOUT - 1);
        else if (tmr != '0)    tmr <= tmr - TW'(1);
    end
`else
    // No counter; TIMEOUT only matters when the timeout feature is compiled in.
    assign timeout_hit = (TIMEOUT < 0);
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (!empty && !led_busy) state_nxt = ISSUE;
            ISSUE:     state_nxt = WAIT_ACK;
            WAIT_ACK:  if (led_busy) state_nxt = WAIT_DONE;
                       else if (timeout_hit) state_nxt = IDLE;
            WAIT_DONE: if (!led_busy) state_nxt = IDLE;
                       else if (timeout_hit) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pop       = (state == ISSUE);
        begin_nxt = (state_nxt == ISSUE);
        to_set    = timeout_hit && (((state == WAIT_ACK) && !led_busy) ||
                                    ((state == WAIT_DONE) && led_busy));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            led_begin_q <= 1'b0;
            led_data_q  <= '0;
            ovf_sticky  <= 1'b0;
            to_sticky   <= 1'b0;
        end else begin
            led_begin_q <= begin_nxt;
            if (begin_nxt) led_data_q <= mem[rd_ptr];
            if (drop)                ovf_sticky <= 1'b1;
            else if (bus.status_clr) ovf_sticky <= 1'b0;
            if (to_set)              to_sticky  <= 1'b1;
            else if (bus.status_clr) to_sticky  <= 1'b0;
        end
    end

    assign bus.cmd_ready    = !full;
    assign bus.led_begin    = led_begin_q;
    assign bus.led_data     = led_data_q;
    assign bus.sched_status = {22'd0, to_sticky, ovf_sticky, 5'(count), full, empty, (state != IDLE)};
endmodule

// File: tb/tb_led_cmd_sched.sv
// Self-checking bench for led_cmd_sched: directed scenarios plus random traffic
// compared every cycle against a queue-based model of the scheduler.
module tb_led_cmd_sched;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    led_cmd_sched_if bus();

    led_cmd_sched #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1 issuing, 2 awaiting busy, 3 awaiting release
    logic [31:0] m_q[$];
    logic [31:0] issued[$];
    int          m_phase;
    int          m_cyc;
    bit          m_ovf;
    bit          m_to;
    logic [31:0] m_data;
    int          led_cnt;

    function automatic void m_reset();
        m_q.delete();
        m_phase = 0;
        m_cyc   = 1;
        m_ovf   = 1'b0;
        m_to    = 1'b0;
        m_data  = '0;
    endfunction

    function automatic void m_step(input bit v, input logic [31:0] d, input bit clr, input bit busy);
        bit was_full = (m_q.size() == DEPTH);
        int nxt      = m_phase;
        bit to_fire  = 1'b0;
        case (m_phase)
            0:       if (m_q.size() > 0 && !busy) begin nxt = 1; m_data = m_q[0]; end
            1:       nxt = 2;
            2:       if (busy) nxt = 3;
            3:       if (!busy) nxt = 0;
            default: nxt = 0;
        endcase
`ifdef LED_SCHED_TIMEOUT_EN
        if (nxt == m_phase && m_phase >= 2 && m_cyc == TIMEOUT) begin
            nxt     = 0;
            to_fire = 1'b1;
        end
`endif
        if (m_phase == 1) void'(m_q.pop_front());
        if (v && !was_full) m_q.push_back(d);
        if (v && was_full) m_ovf = 1'b1;
        else if (clr)      m_ovf = 1'b0;
        if (to_fire)       m_to  = 1'b1;
        else if (clr)      m_to  = 1'b0;
        m_cyc   = (nxt == m_phase) ? m_cyc + 1 : 1;
        m_phase = nxt;
    endfunction

    function automatic logic [31:0] m_status();
        int c = m_q.size();
        return {22'd0, m_to, m_ovf, 5'(c), (c == DEPTH), (c == 0), (m_phase != 0)};
    endfunction

    task automatic cyc(input bit v, input logic [31:0] d, input bit clr, input bit busy);
        bus.cmd_valid  = v;
        bus.cmd_data   = d;
        bus.status_clr = clr;
        bus.led_state  = {31'($urandom()), busy};
        @(posedge clock);
        m_step(v, d, clr, busy);
        #1;
        chk("led_begin", 32'(bus.led_begin), 32'(m_phase == 1));
        chk("led_data", bus.led_data, m_data);
        chk("status", bus.sched_status, m_status());
        chk("cmd_ready", 32'(bus.cmd_ready), 32'(m_q.size() < DEPTH));
        if (bus.led_begin) issued.push_back(bus.led_data);
    endtask

    task automatic apply_reset();
        reset_n        = 1'b0;
        bus.cmd_valid  = 1'b0;
        bus.cmd_data   = '0;
        bus.status_clr = 1'b0;
        bus.led_state  = '0;
        #1;
        chk("rst_status", bus.sched_status, 32'h0000_0002);
        chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_begin", 32'(bus.led_begin), 32'd0);
        chk("rst_data", bus.led_data, 32'd0);
        m_reset();
        reset_n = 1'b1;
    endtask

    // Simple LED8 stand-in: busy for three cycles after each begin pulse.
    task automatic run_led(input int n);
        for (int k = 0; k < n; k++) begin
            cyc(1'b0, '0, 1'b0, led_cnt > 0);
            if (bus.led_begin) led_cnt = 3;
            else if (led_cnt > 0) led_cnt--;
        end
    endtask

    initial begin
        bit          v, clr, busy;
        logic [31:0] d;

        led_cnt = 0;
        apply_reset();

        // Latency and status bit 0 through one handshake
        cyc(1'b1, 32'hA5, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        chk("latency_begin", 32'(bus.led_begin), 32'd1);
        chk("latency_data", bus.led_data, 32'hA5);
        cyc(1'b0, '0, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b1);
        chk("busy_status0", 32'(bus.sched_status[0]), 32'd1);
        chk("data_held", bus.led_data, 32'hA5);
        cyc(1'b0, '0, 1'b0, 1'b0);
        chk("idle_status0", 32'(bus.sched_status[0]), 32'd0);

        // Overfill while LED busy, then drain in order
        for (int i = 1; i <= 5; i++) begin
            cyc(1'b1, 32'(i), 1'b0, 1'b1);
            if (i == 4) chk("ready_full", 32'(bus.cmd_ready), 32'd0);
        end
        chk("ovf_set", 32'(bus.sched_status[8]), 32'd1);
        chk("count_full", 32'(bus.sched_status[7:3]), 32'd4);
        issued.delete();
        led_cnt = 0;
        run_led(40);
        chk("issued_n", 32'(issued.size()), 32'd4);
        for (int i = 0; i < issued.size(); i++) chk("issue_order", issued[i], 32'(i + 1));

        // Full FIFO with simultaneous pop and push
        apply_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'h100 + 32'(i), 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b0);
        chk("issue_when_full", 32'(bus.led_begin), 32'd1);
        cyc(1'b1, 32'hDEAD, 1'b0, 1'b1);
        chk("pop_push_count", 32'(bus.sched_status[7:3]), 32'd3);
        chk("pop_push_ovf", 32'(bus.sched_status[8]), 32'd1);

        // Overflow sticky versus status_clr
        cyc(1'b1, 32'h77, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b1);
        chk("clr_alone", 32'(bus.sched_status[8]), 32'd0);
        cyc(1'b1, 32'h88, 1'b1, 1'b1);
        chk("set_wins", 32'(bus.sched_status[8]), 32'd1);
        cyc(1'b0, '0, 1'b1, 1'b1);
        chk("clr_after", 32'(bus.sched_status[8]), 32'd0);

        // LED never acknowledges
        apply_reset();
        cyc(1'b1, 32'h31, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        repeat (8) cyc(1'b0, '0, 1'b0, 1'b0);
        chk("wait_ack_held", 32'(bus.sched_status[0]), 32'd1);
        cyc(1'b0, '0, 1'b0, 1'b0);
`ifdef LED_SCHED_TIMEOUT_EN
        chk("timeout_idle", 32'(bus.sched_status[0]), 32'd0);
        chk("timeout_flag", 32'(bus.sched_status[9]), 32'd1);
`else
        chk("no_timeout_busy", 32'(bus.sched_status[0]), 32'd1);
        chk("no_timeout_flag", 32'(bus.sched_status[9]), 32'd0);
`endif
        repeat (91) cyc(1'b0, '0, 1'b0, 1'b0);

        // Asynchronous reset mid-handshake discards the queue
        apply_reset();
        cyc(1'b1, 32'hC1, 1'b0, 1'b0);
        cyc(1'b1, 32'hC2, 1'b0, 1'b0);
        cyc(1'b1, 32'hC3, 1'b0, 1'b0);
        cyc(1'b1, 32'hC4, 1'b0, 1'b1);
        chk("pre_rst_count", 32'(bus.sched_status[7:3]), 32'd3);
        chk("pre_rst_busy", 32'(bus.sched_status[0]), 32'd1);
        #2;
        apply_reset();
        issued.delete();
        repeat (10) cyc(1'b0, '0, 1'b0, 1'b0);
        chk("no_begin_after_rst", 32'(issued.size()), 32'd0);

        // Random traffic
        apply_reset();
        busy = 1'b0;
        repeat (600) begin
            v   = 1'($urandom_range(0, 1));
            d   = $urandom();
            clr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) busy = !busy;
            cyc(v, d, clr, busy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
